rragmem_seq_ctrl: RTL and testbench

Controls the ld/clr of the RrAg-to-MEM pipeline latch and holds the upstream stages when needed. It expands REP-prefixed instructions into one latch load per iteration, counting down the repeat count while stalling RrAg. It also handles MEM back-pressure and a multi-cycle pipeline flush for mispredicts and exceptions. Sits between RrAg stage control, the RrAg-to-MEM latch, and the flush/stall network from MEM/WB.

---
 rtl/rragmem_seq_ctrl_if.sv | 35 +++
 rtl/rragmem_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_rragmem_seq_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/rragmem_seq_ctrl_if.sv
// RrAg-to-MEM sequencing bundle: upstream instruction info, MEM/flush controls, latch controls.
// Latency: pure wiring, no storage.
// Backpressure: carried by mem_stall (into the controller) and upstream_stall (out of it).
interface rragmem_seq_ctrl_if #(
    parameter int CNT_W = 32
);
    // Upstream / network side
    logic             up_valid;
    logic             up_is_rep;
    logic [CNT_W-1:0] up_rep_num;
    logic             mem_stall;
    logic             flush;
    // Latch control side
    logic             latch_ld;
    logic             latch_clr;
    logic             valid_to_latch;
    logic             upstream_stall;
    logic [CNT_W-1:0] rep_iter;
    logic             rep_active;
    logic             rep_last;

    // master: the surrounding pipeline, which drives requests and observes latch control
    modport master (
        output up_valid, up_is_rep, up_rep_num, mem_stall, flush,
        input  latch_ld, latch_clr, valid_to_latch, upstream_stall,
        input  rep_iter, rep_active, rep_last
    );

    // slave: the sequencing controller
    modport slave (
        input  up_valid, up_is_rep, up_rep_num, mem_stall, flush,
        output latch_ld, latch_clr, valid_to_latch, upstream_stall,
        output rep_iter, rep_active, rep_last
    );
endinterface

// File: rtl/rragmem_seq_ctrl.sv
// RrAg-to-MEM latch sequencer: REP expansion into per-iteration loads, MEM stall hold, multi-cycle flush.
// Latency: all outputs combinational from state/counters/inputs; state advances on posedge clk.
// Backpressure: mem_stall blocks loads and holds RrAg; flush overrides everything and clears the latch.
// Ports: clk, clr (async active-low reset), bus (slave modport of rragmem_seq_ctrl_if).
module rragmem_seq_ctrl #(
    parameter int CNT_W     = 32,
    parameter int FLUSH_CYC = 2
) (
    input  logic                    clk,
    input  logic                    clr,
    rragmem_seq_ctrl_if.slave       bus
);
    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    localparam logic [1:0] ST_PASS  = 2'd0;
    localparam logic [1:0] ST_REP   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [FW-1:0]    FCNT_RELOAD = FW'(FLUSH_CYC - 1);
    localparam logic [FW-1:0]    FCNT_ONE    = FW'(1);

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [FW-1:0]    fcnt, fcnt_nxt;

    logic             ld, lc, vl, st, act, last;
    logic [CNT_W-1:0] iter;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fcnt_nxt  = fcnt;
        ld        = 1'b0;
        lc        = 1'b0;
        vl        = 1'b0;
        st        = 1'b0;
        act       = 1'b0;
        last      = 1'b0;
        iter      = '0;

        if (bus.flush) begin
            // Flush wins over stall and over any pending REP iteration, including the final one.
            lc      = 1'b1;
            cnt_nxt = '0;
            if (FLUSH_CYC > 1) begin
                state_nxt = ST_FLUSH;
                fcnt_nxt  = FCNT_RELOAD;
            end else begin
                state_nxt = ST_PASS;
                fcnt_nxt  = '0;
            end
        end else begin
            case (state)
                ST_FLUSH: begin
                    lc = 1'b1;
                    st = 1'b1;
                    if (fcnt == '0) begin
                        state_nxt = ST_PASS;
                    end else begin
                        fcnt_nxt = fcnt - FCNT_ONE;
                    end
                end
                ST_REP: begin
                    act  = 1'b1;
                    iter = cnt;
                    st   = 1'b1;
                    if (!bus.mem_stall) begin
                        ld = 1'b1;
                        vl = 1'b1;
                        // cnt never goes below 1 here: the load at cnt==1 is the last one,
                        // and RrAg is released on that same edge.
                        if (cnt == CNT_ONE) begin
                            last      = 1'b1;
                            st        = 1'b0;
                            state_nxt = ST_PASS;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt - CNT_ONE;
                        end
                    end
                end
                default: begin
                    if (bus.mem_stall) begin
                        st = 1'b1;
                    end else begin
                        ld = 1'b1;
                        if (bus.up_valid && bus.up_is_rep) begin
                            if (bus.up_rep_num == '0) begin
                                // Zero-iteration REP executes nothing: load a bubble.
                                vl = 1'b0;
                            end else if (bus.up_rep_num == CNT_ONE) begin
                                vl   = 1'b1;
                                iter = CNT_ONE;
                                last = 1'b1;
                            end else begin
                                // First iteration loads now; the rest are issued from REP.
                                vl        = 1'b1;
                                iter      = bus.up_rep_num;
                                st        = 1'b1;
                                act       = 1'b1;
                                state_nxt = ST_REP;
                                cnt_nxt   = bus.up_rep_num - CNT_ONE;
                            end
                        end else begin
                            vl = bus.up_valid;
                        end
                    end
                end
            endcase
        end

        // Outputs take their reset values for as long as reset is held.
        if (!clr) begin
            ld   = 1'b0;
            lc   = 1'b1;
            vl   = 1'b0;
            st   = 1'b0;
            act  = 1'b0;
            last = 1'b0;
            iter = '0;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= ST_PASS;
            cnt   <= '0;
            fcnt  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    assign bus.latch_ld       = ld;
    assign bus.latch_clr      = lc;
    assign bus.valid_to_latch = vl;
    assign bus.upstream_stall = st;
    assign bus.rep_iter       = iter;
    assign bus.rep_active     = act;
    assign bus.rep_last       = last;
endmodule

// File: tb/tb_rragmem_seq_ctrl.sv
// Directed bench for rragmem_seq_ctrl: per-cycle vector table plus hand-written reset sequences.
// Latency: inputs driven on negedge, combinational outputs compared 1ns later.
// Backpressure: mem_stall/flush exercised through the vector table.
module tb_rragmem_seq_ctrl;
    localparam int CNT_W = 32;
    localparam int OW    = 6 + CNT_W;

    // Packed output layout: {ld, clr, vld, stall, active, last, iter}
    localparam logic [OW-1:0] M_ALL   = {OW{1'b1}};
    localparam logic [OW-1:0] M_NOVLD = {4'b1101, 2'b11, {CNT_W{1'b1}}};
    // Flush cycle: only ld, clr, stall are pinned down
    localparam logic [OW-1:0] M_FL    = {4'b1101, 2'b00, {CNT_W{1'b0}}};
    // FLUSH state: ld, clr, stall, active, last
    localparam logic [OW-1:0] M_FST   = {4'b1101, 2'b11, {CNT_W{1'b0}}};

    typedef struct {
        string            name;
        logic             v;
        logic             r;
        logic [CNT_W-1:0] n;
        logic             ms;
        logic             fl;
        logic [OW-1:0]    exp;
        logic [OW-1:0]    mask;
    } vec_t;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rragmem_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

    rragmem_seq_ctrl #(.CNT_W(CNT_W), .FLUSH_CYC(2)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic v, logic r, logic [CNT_W-1:0] n, logic ms, logic fl,
                                logic ld, logic lc, logic vl, logic st, logic [CNT_W-1:0] it,
                                logic a, logic l, logic [OW-1:0] mask);
        vec_t t;
        t.name = name; t.v = v; t.r = r; t.n = n; t.ms = ms; t.fl = fl;
        t.exp  = {ld, lc, vl, st, a, l, it};
        t.mask = mask;
        return t;
    endfunction

    task automatic drive(logic v, logic r, logic [CNT_W-1:0] n, logic ms, logic fl);
        bus.up_valid   = v;
        bus.up_is_rep  = r;
        bus.up_rep_num = n;
        bus.mem_stall  = ms;
        bus.flush      = fl;
    endtask

    task automatic check(string name, logic [OW-1:0] exp, logic [OW-1:0] mask);
        logic [OW-1:0] act;
        act = {bus.latch_ld, bus.latch_clr, bus.valid_to_latch, bus.upstream_stall,
               bus.rep_active, bus.rep_last, bus.rep_iter};
        checks++;
        if ((act & mask) !== (exp & mask)) begin
            errors++;
            $display("FAIL %s: got {ld,clr,vld,stall,act,last,iter}=%b_%h expected %b_%h (mask %h)",
                     name, act[OW-1:CNT_W], act[CNT_W-1:0], exp[OW-1:CNT_W], exp[CNT_W-1:0], mask);
        end
    endtask

    initial begin
        logic [CNT_W-1:0] big;
        big = {CNT_W{1'b1}};

        //          name          v  r  n          ms fl  ld lc vl st it         a  l  mask
        vecs.push_back(mk("plain",      1, 0, 0,         0, 0,  1, 0, 1, 0, 0,         0, 0, M_ALL));
        vecs.push_back(mk("bubble",     0, 0, 0,         0, 0,  1, 0, 0, 0, 0,         0, 0, M_ALL));
        vecs.push_back(mk("pass_stall", 1, 0, 0,         1, 0,  0, 0, 0, 1, 0,         0, 0, M_NOVLD));
        // REP 3, no stall
        vecs.push_back(mk("rep3_i3",    1, 1, 3,         0, 0,  1, 0, 1, 1, 3,         1, 0, M_ALL));
        vecs.push_back(mk("rep3_i2",    1, 1, 3,         0, 0,  1, 0, 1, 1, 2,         1, 0, M_ALL));
        vecs.push_back(mk("rep3_i1",    1, 1, 3,         0, 0,  1, 0, 1, 0, 1,         1, 1, M_ALL));
        vecs.push_back(mk("rep3_after", 1, 0, 0,         0, 0,  1, 0, 1, 0, 0,         0, 0, M_ALL));
        // REP 3 with a MEM stall in the second REP cycle
        vecs.push_back(mk("rep3s_i3",   1, 1, 3,         0, 0,  1, 0, 1, 1, 3,         1, 0, M_ALL));
        vecs.push_back(mk("rep3s_hold", 1, 1, 3,         1, 0,  0, 0, 0, 1, 2,         1, 0, M_NOVLD));
        vecs.push_back(mk("rep3s_i2",   1, 1, 3,         0, 0,  1, 0, 1, 1, 2,         1, 0, M_ALL));
        vecs.push_back(mk("rep3s_i1",   1, 1, 3,         0, 0,  1, 0, 1, 0, 1,         1, 1, M_ALL));
        // Degenerate REP counts
        vecs.push_back(mk("rep0",       1, 1, 0,         0, 0,  1, 0, 0, 0, 0,         0, 0, M_ALL));
        vecs.push_back(mk("rep1",       1, 1, 1,         0, 0,  1, 0, 1, 0, 1,         0, 1, M_ALL));
        // REP 5 flushed after two iterations
        vecs.push_back(mk("rep5_i5",    1, 1, 5,         0, 0,  1, 0, 1, 1, 5,         1, 0, M_ALL));
        vecs.push_back(mk("rep5_i4",    1, 1, 5,         0, 0,  1, 0, 1, 1, 4,         1, 0, M_ALL));
        vecs.push_back(mk("rep5_flush", 1, 1, 5,         0, 1,  0, 1, 0, 0, 0,         0, 0, M_FL));
        vecs.push_back(mk("rep5_fl1",   1, 1, 5,         0, 0,  0, 1, 0, 1, 0,         0, 0, M_FST));
        vecs.push_back(mk("rep5_fl2",   1, 1, 5,         0, 0,  0, 1, 0, 1, 0,         0, 0, M_FST));
        vecs.push_back(mk("rep5_pass",  1, 0, 0,         0, 0,  1, 0, 1, 0, 0,         0, 0, M_ALL));
        // Flush together with a MEM stall
        vecs.push_back(mk("fl_mstall",  1, 0, 0,         1, 1,  0, 1, 0, 0, 0,         0, 0, M_FL));
        vecs.push_back(mk("fl_ms_f1",   1, 0, 0,         1, 0,  0, 1, 0, 1, 0,         0, 0, M_FST));
        vecs.push_back(mk("fl_ms_f2",   1, 0, 0,         0, 0,  0, 1, 0, 1, 0,         0, 0, M_FST));
        vecs.push_back(mk("fl_ms_pass", 0, 0, 0,         0, 0,  1, 0, 0, 0, 0,         0, 0, M_ALL));
        // Flush on the final REP load, then a re-flush while in FLUSH
        vecs.push_back(mk("rep2_i2",    1, 1, 2,         0, 0,  1, 0, 1, 1, 2,         1, 0, M_ALL));
        vecs.push_back(mk("rep2_flast", 1, 1, 2,         0, 1,  0, 1, 0, 0, 0,         0, 0, M_FL));
        vecs.push_back(mk("refl",       0, 0, 0,         0, 1,  0, 1, 0, 0, 0,         0, 0, M_FL));
        vecs.push_back(mk("refl_f1",    0, 0, 0,         0, 0,  0, 1, 0, 1, 0,         0, 0, M_FST));
        vecs.push_back(mk("refl_f2",    0, 0, 0,         0, 0,  0, 1, 0, 1, 0,         0, 0, M_FST));
        vecs.push_back(mk("refl_pass",  0, 0, 0,         0, 0,  1, 0, 0, 0, 0,         0, 0, M_ALL));
        // Maximum count: no wrap on entry or decrement
        vecs.push_back(mk("max_i0",     1, 1, big,       0, 0,  1, 0, 1, 1, big,       1, 0, M_ALL));
        vecs.push_back(mk("max_i1",     1, 1, big,       0, 0,  1, 0, 1, 1, big - 1,   1, 0, M_ALL));
        vecs.push_back(mk("max_i2",     1, 1, big,       0, 0,  1, 0, 1, 1, big - 2,   1, 0, M_ALL));
        vecs.push_back(mk("max_hold",   1, 1, big,       1, 0,  0, 0, 0, 1, big - 3,   1, 0, M_NOVLD));
        vecs.push_back(mk("max_flush",  1, 1, big,       0, 1,  0, 1, 0, 0, 0,         0, 0, M_FL));
        vecs.push_back(mk("max_f1",     0, 0, 0,         0, 0,  0, 1, 0, 1, 0,         0, 0, M_FST));
        vecs.push_back(mk("max_f2",     0, 0, 0,         0, 0,  0, 1, 0, 1, 0,         0, 0, M_FST));
        vecs.push_back(mk("max_pass",   1, 0, 0,         0, 0,  1, 0, 1, 0, 0,         0, 0, M_ALL));

        // Reset held with random inputs
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
            #1;
            check($sformatf("reset_%0d", i), {4'b0100, 2'b00, {CNT_W{1'b0}}}, M_ALL);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        clr = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].r, vecs[i].n, vecs[i].ms, vecs[i].fl);
            #1;
            check(vecs[i].name, vecs[i].exp, vecs[i].mask);
        end

        // Reset asserted mid-REP, away from any clock edge
        @(negedge clk);
        drive(1'b1, 1'b1, 4, 1'b0, 1'b0);
        #1;
        check("mid_rep_i4", {4'b1011, 2'b10, CNT_W'(4)}, M_ALL);
        @(negedge clk);
        #1;
        check("mid_rep_i3", {4'b1011, 2'b10, CNT_W'(3)}, M_ALL);
        #2;
        clr = 1'b0;
        #1;
        check("mid_rep_rst", {4'b0100, 2'b00, {CNT_W{1'b0}}}, M_ALL);
        @(negedge clk);
        clr = 1'b1;
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        #1;
        check("mid_rep_pass", {4'b1010, 2'b00, {CNT_W{1'b0}}}, M_ALL);

        // Reset asserted mid-FLUSH
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
        #1;
        check("mid_fl_flush", {4'b0100, 2'b00, {CNT_W{1'b0}}}, M_FL);
        @(negedge clk);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        #3;
        clr = 1'b0;
        #1;
        check("mid_fl_rst", {4'b0100, 2'b00, {CNT_W{1'b0}}}, M_ALL);
        @(negedge clk);
        clr = 1'b1;
        #1;
        check("mid_fl_pass", {4'b1010, 2'b00, {CNT_W{1'b0}}}, M_ALL);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
